// File: rtl/gpu_noc_pkg.sv
// Shared definitions for the GPU network-on-chip network interface.
// Holds the flit geometry, the dest/payload field positions, the default
// broadcast ID and small helpers for field extraction and saturating counts.
// No ports (package).
package gpu_noc_pkg;

  localparam int FLIT_W    = 16;
  localparam int DEST_W    = 6;
  localparam int PAYLOAD_W = 10;

  // Field slices inside a flit: [15:10] dest, [9:0] payload
  localparam int DEST_MSB    = FLIT_W - 1;
  localparam int DEST_LSB    = FLIT_W - DEST_W;
  localparam int PAYLOAD_MSB = PAYLOAD_W - 1;
  localparam int PAYLOAD_LSB = 0;

  localparam logic [DEST_W-1:0] BCAST_ID_DEFAULT = 6'h3F;
  localparam logic [15:0]       COUNT_MAX        = 16'hFFFF;

  function automatic logic [DEST_W-1:0] flit_dest(input logic [FLIT_W-1:0] flit);
    return flit[DEST_MSB:DEST_LSB];
  endfunction

  function automatic logic [PAYLOAD_W-1:0] flit_payload(input logic [FLIT_W-1:0] flit);
    return flit[PAYLOAD_MSB:PAYLOAD_LSB];
  endfunction

  // Counters stick at all-ones instead of wrapping back to zero
  function automatic logic [15:0] sat_inc(input logic [15:0] count);
    return (count == COUNT_MAX) ? count : count + 16'd1;
  endfunction

endpackage

// File: rtl/ni_fifo.sv
// First-word-through FIFO used for both the TX and RX paths of the NI.
// The head entry is presented combinationally, so a write becomes visible
// on head the cycle after it is clocked in.
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset (empties the FIFO)
//   push       write push_data when not full
//   push_data  entry to write
//   pop        drop the head entry when not empty
//   head       current head entry (reads zero when empty)
//   full       DEPTH entries held
//   empty      no entries held
module ni_fifo
  import gpu_noc_pkg::*;
#(
  parameter int WIDTH = FLIT_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit tells full apart from empty when the indices match
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Storage carries no reset; validity is tracked purely by the pointers
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/gpu_noc_ni.sv
// Network interface between a GPU core and a NoC router.
// GPU flits are buffered in a TX FIFO and sent to the router, except flits
// addressed to this node, which loop back into the RX FIFO. Router flits
// addressed to this node or to the broadcast ID are buffered in the RX FIFO
// and delivered to the GPU; all others are dropped and counted.
// Ports:
//   ACLK, ARESETn                  clock, synchronous active-low reset
//   gpu_tx_data/valid/ready        GPU -> NI flit channel
//   gpu_rx_data/valid/ready        NI -> GPU flit channel
//   noc_tx_data/valid/ready        NI -> router flit channel
//   noc_rx_data/valid/ready        router -> NI flit channel
//   tx_count, rx_count, drop_count saturating flit counters
module gpu_noc_ni
  import gpu_noc_pkg::*;
#(
  parameter logic [DEST_W-1:0] NODE_ID  = 6'd27,
  parameter int                TX_DEPTH = 4,
  parameter int                RX_DEPTH = 4,
  parameter logic [DEST_W-1:0] BCAST_ID = BCAST_ID_DEFAULT
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [FLIT_W-1:0] gpu_tx_data,
  input  logic              gpu_tx_valid,
  output logic              gpu_tx_ready,
  output logic [FLIT_W-1:0] gpu_rx_data,
  output logic              gpu_rx_valid,
  input  logic              gpu_rx_ready,
  output logic [FLIT_W-1:0] noc_tx_data,
  output logic              noc_tx_valid,
  input  logic              noc_tx_ready,
  input  logic [FLIT_W-1:0] noc_rx_data,
  input  logic              noc_rx_valid,
  output logic              noc_rx_ready,
  output logic [15:0]       tx_count,
  output logic [15:0]       rx_count,
  output logic [15:0]       drop_count
);

  logic              rst_done;
  logic [FLIT_W-1:0] tx_head;
  logic              tx_full;
  logic              tx_empty;
  logic              tx_push;
  logic              tx_pop;
  logic [FLIT_W-1:0] rx_head;
  logic              rx_full;
  logic              rx_empty;
  logic              rx_push;
  logic [FLIT_W-1:0] rx_push_data;
  logic              head_local;
  logic              noc_tx_fire;
  logic              noc_rx_fire;
  logic              noc_rx_match;
  logic              noc_rx_write;
  logic              noc_rx_drop;
  logic              loopback_move;
  logic              gpu_rx_fire;

  // Holds the ready/valid outputs low while reset is sampled, so they rise
  // only in the first cycle after ARESETn is seen high
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
    end
  end

  // A head addressed to this node never goes to the router; broadcast
  // flits are excluded so they always leave through the NoC
  assign head_local = !tx_empty && (flit_dest(tx_head) == NODE_ID) &&
                      (flit_dest(tx_head) != BCAST_ID);

  assign gpu_tx_ready = rst_done && !tx_full;
  assign noc_rx_ready = rst_done && !rx_full;
  assign noc_tx_valid = rst_done && !tx_empty && !head_local;
  assign noc_tx_data  = noc_tx_valid ? tx_head : '0;
  assign gpu_rx_valid = rst_done && !rx_empty;
  assign gpu_rx_data  = gpu_rx_valid ? rx_head : '0;

  assign tx_push      = gpu_tx_valid && gpu_tx_ready;
  assign noc_tx_fire  = noc_tx_valid && noc_tx_ready;
  assign noc_rx_fire  = noc_rx_valid && noc_rx_ready;
  assign gpu_rx_fire  = gpu_rx_valid && gpu_rx_ready;

  assign noc_rx_match = (flit_dest(noc_rx_data) == NODE_ID) ||
                        (flit_dest(noc_rx_data) == BCAST_ID);
  assign noc_rx_write = noc_rx_fire && noc_rx_match;
  assign noc_rx_drop  = noc_rx_fire && !noc_rx_match;

  // The RX FIFO has a single write port: a router write takes priority and
  // the loopback head simply stays in the TX FIFO to retry next cycle
  assign loopback_move = rst_done && head_local && !rx_full && !noc_rx_write;

  assign tx_pop       = noc_tx_fire || loopback_move;
  assign rx_push      = noc_rx_write || loopback_move;
  assign rx_push_data = noc_rx_write ? noc_rx_data : tx_head;

  ni_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk       (ACLK),
    .rst_n     (ARESETn),
    .push      (tx_push),
    .push_data (gpu_tx_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  ni_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (ACLK),
    .rst_n     (ARESETn),
    .push      (rx_push),
    .push_data (rx_push_data),
    .pop       (gpu_rx_fire),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  // Flit statistics, each saturating at all-ones
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      tx_count   <= '0;
      rx_count   <= '0;
      drop_count <= '0;
    end else begin
      if (noc_tx_fire) tx_count   <= sat_inc(tx_count);
      if (gpu_rx_fire) rx_count   <= sat_inc(rx_count);
      if (noc_rx_drop) drop_count <= sat_inc(drop_count);
    end
  end

endmodule

// File: doc/gpu_noc_ni.md
GPU_NOC_NI -- requirements
Module: gpu_noc_ni

Interface
REQ-001 SHALL have parameter NODE_ID, default 27, meaning the 6-bit destination ID this node accepts.
REQ-002 SHALL have parameter TX_DEPTH, default 4, meaning the TX FIFO entry count (power of two, >=2).
REQ-003 SHALL have parameter RX_DEPTH, default 4, meaning the RX FIFO entry count (power of two, >=2).
REQ-004 SHALL have parameter BCAST_ID, default 6'h3F, meaning the destination ID accepted by every node.
REQ-005 SHALL use one clock; reset is synchronous and active-low, on ports ACLK and ARESETn.
REQ-006 SHALL have these ports, one per line (name, direction, width, meaning):
- ACLK  in  1  clock
- ARESETn  in  1  synchronous active-low reset
- gpu_tx_data  in  16  flit from GPU: [15:10] dest, [9:0] payload
- gpu_tx_valid  in  1  GPU flit valid, may be a one-cycle pulse
- gpu_tx_ready  out  1  NI can accept a GPU flit
- gpu_rx_data  out  16  flit to GPU
- gpu_rx_valid  out  1  flit to GPU valid
- gpu_rx_ready  in  1  GPU accepts the flit
- noc_tx_data  out  16  flit to router
- noc_tx_valid  out  1  router flit valid
- noc_tx_ready  in  1  router accepts
- noc_rx_data  in  16  flit from router
- noc_rx_valid  in  1  router flit valid
- noc_rx_ready  out  1  NI can accept a router flit
- tx_count  out  16  flits sent to the NoC, saturating
- rx_count  out  16  flits delivered to the GPU, saturating
- drop_count  out  16  router flits discarded as misaddressed, saturating

Function
REQ-007 A transfer SHALL occur on every rising ACLK edge at which valid and ready are both high, on every channel.
REQ-008 gpu_tx_ready SHALL equal !tx_full and SHALL NOT depend combinationally on gpu_tx_valid or on any NoC input.
REQ-009 Each accepted GPU flit SHALL be written to the TX FIFO; the FIFO is first-word-through, so the head is visible the cycle after the write.
REQ-010 When the TX head dest != NODE_ID, noc_tx_valid SHALL be !tx_empty and noc_tx_data SHALL be the head; the head SHALL pop on the NoC handshake.
REQ-011 Loopback: when the TX head dest == NODE_ID, noc_tx_valid SHALL stay 0; the head SHALL move to the RX FIFO in one cycle when the RX FIFO is not full and no NoC RX write occurs that cycle.
REQ-012 A GPU flit with dest == BCAST_ID SHALL go to the NoC only and SHALL NOT be looped back.
REQ-013 noc_rx_ready SHALL equal !rx_full.
REQ-014 An accepted router flit with dest == NODE_ID or dest == BCAST_ID SHALL be written to the RX FIFO; any other dest SHALL be discarded and SHALL increment drop_count.
REQ-015 On a simultaneous NoC RX write and loopback request, the NoC write SHALL win and the loopback SHALL retry the next cycle.
REQ-016 gpu_rx_valid SHALL be !rx_empty and gpu_rx_data SHALL be the RX head; the head SHALL pop on the GPU handshake.
REQ-017 Both FIFOs SHALL support a push and a pop in the same cycle when not empty; occupancy is then unchanged; pointers wrap modulo depth.
REQ-018 tx_count SHALL increment on the NoC TX handshake; rx_count SHALL increment on the GPU RX handshake; all counters SHALL saturate at 16'hFFFF.
REQ-019 Flit order SHALL be preserved within each FIFO; the router-to-GPU minimum latency SHALL be 1 cycle.

Reset
REQ-020 While ARESETn is low at a clock edge, the block SHALL empty both FIFOs, zero all counters, and drive all valid and ready outputs to 0; data outputs SHALL read 16'h0000.
REQ-021 A reset asserted mid-transfer SHALL discard all buffered flits with no partial delivery; the ready outputs SHALL rise in the first cycle after ARESETn is sampled high.

Structure
REQ-022 FLIT_W=16, DEST_W=6, PAYLOAD_W=10, the dest/payload field slices and the default BCAST_ID SHALL reside in shared package gpu_noc_pkg.
REQ-023 Both FIFOs SHALL be instances of one sub-module, ni_fifo (parameters WIDTH and DEPTH; outputs full, empty, head).

Verification
REQ-024 NODE_ID=27; GPU pulses 16'h7123 (dest 28) with noc_tx_ready=1 -> noc_tx_data=16'h7123, valid the next cycle; tx_count=1.
REQ-025 GPU sends 16'h6C55 (dest 27) -> noc_tx_valid stays 0; gpu_rx_data=16'h6C55 within 3 cycles; rx_count=1 after the handshake.
REQ-026 Router sends 16'h7001 (dest 28) -> noc_rx_ready=1, no gpu_rx_valid, drop_count=1; router sends 16'hFC0A (broadcast) -> delivered to the GPU.
REQ-027 With noc_tx_ready=0, push 4 flits -> gpu_tx_ready=0; the 5th pulse is lost; raising noc_tx_ready drains the 4 flits in order.
REQ-028 Loopback head pending while the router writes a dest-27 flit in the same cycle -> the router flit is delivered first, the loopback flit next; assert ARESETn=0 with both FIFOs holding flits -> all counts 0, all valid outputs 0, nothing delivered afterward.
